// File: rtl/uart_rx_fsm_if.sv
// Serial-side interface of the UART receiver: the raw line in and the
// registered {parity, data} word out.
interface uart_rx_fsm_if #(
    parameter int DATA_BITS = 8
);
    logic                 serialInput;
    logic [DATA_BITS:0]   dataParityOut;

    modport master (
        output serialInput,
        input  dataParityOut
    );

    modport slave (
        input  serialInput,
        output dataParityOut
    );
endinterface

// File: rtl/uart_rx_fsm.sv
// UART receive FSM clocked by the oversampling baud tick: 1 start bit, DATA_BITS
// data bits (LSB first), 1 raw parity bit and 1 stop bit per frame.
module uart_rx_fsm #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic          baudRateOut,
    input  logic          rst,
    uart_rx_fsm_if.slave  rx
);
    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] MID_START = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BIT_W-1:0]       bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   parity_q, parity_d;
    logic [DATA_BITS:0]     out_q, out_d;
    logic                   sync1_q, sync2_q;
    logic                   line;

    assign line             = sync2_q;
    assign rx.dataParityOut = out_q;

    // Synchroniser resets to the idle-high level so a reset never looks like a start edge.
    always_ff @(posedge baudRateOut) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            out_q     <= '0;
        end else begin
            sync1_q   <= rx.serialInput;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            out_q     <= out_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!line) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == MID_START) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = line ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == LAST_TICK) begin
                    cnt_d            = '0;
                    shift_d[bit_idx_q] = line;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = PARITY;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PARITY: begin
                if (cnt_q == LAST_TICK) begin
                    cnt_d    = '0;
                    parity_d = line;
                    state_d  = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == LAST_TICK) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // A low stop sample is a framing error: the frame is dropped and the old word kept.
    always_comb begin
        out_d = out_q;
        if (state_q == STOP && cnt_q == LAST_TICK && line) begin
            out_d = {parity_q, shift_q};
        end
    end
endmodule

// File: tb/tb_uart_rx_fsm.sv
// Scoreboard bench for uart_rx_fsm: frames push expected words and arrival ticks,
// a negedge monitor pops and compares whenever dataParityOut changes.
`timescale 1ns/1ps
module tb_uart_rx_fsm;
    localparam int OS = 16;
    localparam int DB = 8;

    typedef struct {
        logic [DB:0] value;
        int unsigned tick;
    } exp_t;

    logic        baudRateOut = 1'b0;
    logic        rst;
    int unsigned cycle_count = 0;
    int          assertions  = 0;
    int          failures    = 0;
    bit          mon_en      = 1'b0;
    logic [DB:0] prev_out;
    exp_t        exp_q[$];

    uart_rx_fsm_if #(.DATA_BITS(DB)) rx_if ();

    uart_rx_fsm #(
        .OVERSAMPLE(OS),
        .DATA_BITS (DB)
    ) dut (
        .baudRateOut(baudRateOut),
        .rst        (rst),
        .rx         (rx_if.slave)
    );

    always #13020 baudRateOut = ~baudRateOut;

    always @(posedge baudRateOut) begin
        cycle_count <= cycle_count + 1;
        if (cycle_count > 20000) begin
            $display("[TB] FAIL watchdog: cycle %0d exceeded limit 20000", cycle_count);
            $fatal(1, "[TB] watchdog expired");
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic driveBit(input logic b);
        rx_if.serialInput = b;
        repeat (OS) @(negedge baudRateOut);
    endtask

    // Sends one frame starting at a negedge; accepted frames land 171 counted ticks later
    // (2 synchroniser ticks, 1 idle detect, 8 + 16*10 to the stop sample).
    task automatic applyStimulus(input logic [DB-1:0] data, input logic parity,
                                 input logic stop, input int idle);
        exp_t e;
        if (stop) begin
            e.value = {parity, data};
            e.tick  = cycle_count + 171;
            exp_q.push_back(e);
        end
        driveBit(1'b0);
        for (int i = 0; i < DB; i++) driveBit(data[i]);
        driveBit(parity);
        driveBit(stop);
        rx_if.serialInput = 1'b1;
        repeat (idle) @(negedge baudRateOut);
    endtask

    always @(negedge baudRateOut) begin
        if (mon_en && rx_if.dataParityOut !== prev_out) begin
            if (exp_q.size() == 0) begin
                assertions++;
                failures++;
                $display("[TB] FAIL unexpected output: got %0h at tick %0d, expected no change",
                         rx_if.dataParityOut, cycle_count);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("output value", 32'(rx_if.dataParityOut), 32'(e.value));
                checkOutput("output tick", cycle_count, e.tick);
            end
            prev_out = rx_if.dataParityOut;
        end
    end

    initial begin
        exp_t e;
        int   wait_ticks;
        rst = 1'b1;
        rx_if.serialInput = 1'b1;
        repeat (2) @(negedge baudRateOut);
        rst = 1'b0;
        checkOutput("reset value", 32'(rx_if.dataParityOut), 32'h000);
        prev_out = 9'h000;
        mon_en   = 1'b1;

        $display("[TB] idle line after reset");
        repeat (1000) @(negedge baudRateOut);
        checkOutput("idle hold", 32'(rx_if.dataParityOut), 32'h000);

        $display("[TB] nominal frame 0x55 parity 1");
        applyStimulus(8'h55, 1'b1, 1'b1, 40);
        checkOutput("nominal hold", 32'(rx_if.dataParityOut), 32'h155);

        $display("[TB] glitch then frame 0xA3 parity 0");
        rx_if.serialInput = 1'b0;
        repeat (5) @(negedge baudRateOut);
        rx_if.serialInput = 1'b1;
        repeat (30) @(negedge baudRateOut);
        checkOutput("glitch ignored", 32'(rx_if.dataParityOut), 32'h155);
        applyStimulus(8'hA3, 1'b0, 1'b1, 40);

        $display("[TB] framing error then frame 0x81 parity 1");
        applyStimulus(8'h0F, 1'b1, 1'b0, 40);
        checkOutput("framing error hold", 32'(rx_if.dataParityOut), 32'h0A3);
        applyStimulus(8'h81, 1'b1, 1'b1, 40);

        $display("[TB] back-to-back frames 0x3C and 0xC3");
        applyStimulus(8'h3C, 1'b0, 1'b1, 0);
        applyStimulus(8'hC3, 1'b1, 1'b1, 40);

        $display("[TB] reset during data bit 4");
        driveBit(1'b0);
        for (int i = 0; i < 4; i++) driveBit(1'b1);
        rx_if.serialInput = 1'b1;
        repeat (8) @(negedge baudRateOut);
        e.value = 9'h000;
        e.tick  = cycle_count + 1;
        exp_q.push_back(e);
        rst = 1'b1;
        repeat (2) @(negedge baudRateOut);
        rst = 1'b0;
        repeat (40) @(negedge baudRateOut);
        checkOutput("mid-frame reset", 32'(rx_if.dataParityOut), 32'h000);
        applyStimulus(8'hFF, 1'b1, 1'b1, 40);

        wait_ticks = 0;
        while (exp_q.size() != 0 && wait_ticks < 400) begin
            @(negedge baudRateOut);
            wait_ticks++;
        end
        checkOutput("scoreboard drained", 32'(exp_q.size()), 32'd0);
        checkOutput("final value", 32'(rx_if.dataParityOut), 32'h1FF);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule
